// File: rtl/jelly_bilinear_quad_sampler_if.sv
// Bus bundle for the bilinear quad sampler: coordinate stream in, pixel stream out,
// and the request/response sides of the attached quad-read RAM.
interface jelly_bilinear_quad_sampler_if #(
    parameter int USER_WIDTH   = 0,
    parameter int ADDR_X_WIDTH = 8,
    parameter int ADDR_Y_WIDTH = 8,
    parameter int FRAC_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8
) ();
    localparam int USER_BITS      = (USER_WIDTH > 0) ? USER_WIDTH : 1;
    localparam int MEM_USER_WIDTH = USER_BITS + 2*FRAC_WIDTH;

    logic [USER_BITS-1:0]               s_user;
    logic [ADDR_X_WIDTH+FRAC_WIDTH-1:0] s_x;
    logic [ADDR_Y_WIDTH+FRAC_WIDTH-1:0] s_y;
    logic                               s_valid;
    logic                               s_ready;

    logic [USER_BITS-1:0]               m_user;
    logic [DATA_WIDTH-1:0]              m_data;
    logic                               m_valid;
    logic                               m_ready;

    logic                               mem_cke;
    logic [MEM_USER_WIDTH-1:0]          mem_s_user;
    logic [ADDR_X_WIDTH-1:0]            mem_s_addrx;
    logic [ADDR_Y_WIDTH-1:0]            mem_s_addry;
    logic                               mem_s_valid;
    logic [MEM_USER_WIDTH-1:0]          mem_m_user;
    logic [DATA_WIDTH-1:0]              mem_m_data0;
    logic [DATA_WIDTH-1:0]              mem_m_data1;
    logic [DATA_WIDTH-1:0]              mem_m_data2;
    logic [DATA_WIDTH-1:0]              mem_m_data3;
    logic                               mem_m_valid;

    modport master (
        input  s_user, s_x, s_y, s_valid, m_ready,
               mem_m_user, mem_m_data0, mem_m_data1, mem_m_data2, mem_m_data3, mem_m_valid,
        output s_ready, m_user, m_data, m_valid,
               mem_cke, mem_s_user, mem_s_addrx, mem_s_addry, mem_s_valid
    );

    modport slave (
        output s_user, s_x, s_y, s_valid, m_ready,
               mem_m_user, mem_m_data0, mem_m_data1, mem_m_data2, mem_m_data3, mem_m_valid,
        input  s_ready, m_user, m_data, m_valid,
               mem_cke, mem_s_user, mem_s_addrx, mem_s_addry, mem_s_valid
    );
endinterface

// File: rtl/jelly_bilinear_quad_sampler.sv
// Bilinear sampler: issues one quad read per coordinate and blends the four neighbours.
// Optional JELLY_BILINEAR_CLAMP_EN zeroes the fraction on the last row/column (edge clamp).
module jelly_bilinear_quad_sampler #(
    parameter int USER_WIDTH   = 0,
    parameter int ADDR_X_WIDTH = 8,
    parameter int ADDR_Y_WIDTH = 8,
    parameter int FRAC_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    jelly_bilinear_quad_sampler_if.master   bus
);
    localparam int USER_BITS      = (USER_WIDTH > 0) ? USER_WIDTH : 1;
    localparam int MEM_USER_WIDTH = USER_BITS + 2*FRAC_WIDTH;
    localparam int X_WIDTH        = ADDR_X_WIDTH + FRAC_WIDTH;
    localparam int Y_WIDTH        = ADDR_Y_WIDTH + FRAC_WIDTH;
    localparam int TOP_WIDTH      = DATA_WIDTH + FRAC_WIDTH;
    localparam int V_WIDTH        = DATA_WIDTH + 2*FRAC_WIDTH;
    localparam logic [FRAC_WIDTH:0]  W_ONE      = {1'b1, {FRAC_WIDTH{1'b0}}};
    localparam logic [V_WIDTH-1:0]   ROUND_HALF = V_WIDTH'(1) << (2*FRAC_WIDTH-1);

    logic                       cke;
    logic                       m_valid_out;

    logic [ADDR_X_WIDTH-1:0]    addrx_d, addrx_q;
    logic [ADDR_Y_WIDTH-1:0]    addry_d, addry_q;
    logic [MEM_USER_WIDTH-1:0]  mem_user_d, mem_user_q;
    logic                       s0_valid_d, s0_valid_q;

    logic [TOP_WIDTH-1:0]       top_d, top_q;
    logic [TOP_WIDTH-1:0]       bot_d, bot_q;
    logic [FRAC_WIDTH-1:0]      fy_a_d, fy_a_q;
    logic [USER_BITS-1:0]       user_a_d, user_a_q;
    logic                       valid_a_d, valid_a_q;

    logic [V_WIDTH-1:0]         v_d, v_q;
    logic [USER_BITS-1:0]       user_b_d, user_b_q;
    logic                       valid_b_d, valid_b_q;

    logic [DATA_WIDTH-1:0]      m_data_d, m_data_q;
    logic [USER_BITS-1:0]       m_user_d, m_user_q;
    logic                       m_valid_d, m_valid_q;

    logic [ADDR_X_WIDTH-1:0]    s_xi;
    logic [ADDR_Y_WIDTH-1:0]    s_yi;
    logic [FRAC_WIDTH-1:0]      s_fx, s_fy;
    logic [FRAC_WIDTH-1:0]      r_fx, r_fy;
    logic [USER_BITS-1:0]       r_user;
    logic [FRAC_WIDTH:0]        w_fx, w_fy;

    // Outputs are forced idle while reset is held, independent of register contents.
    assign m_valid_out     = m_valid_q & ~reset;
    assign cke             = bus.m_ready | ~m_valid_out;
    assign bus.s_ready     = cke;
    assign bus.mem_cke     = cke;
    assign bus.m_valid     = m_valid_out;
    assign bus.m_data      = m_data_q;
    assign bus.m_user      = m_user_q;
    assign bus.mem_s_addrx = addrx_q;
    assign bus.mem_s_addry = addry_q;
    assign bus.mem_s_user  = mem_user_q;
    assign bus.mem_s_valid = s0_valid_q & ~reset;

    assign r_fx   = bus.mem_m_user[FRAC_WIDTH-1:0];
    assign r_fy   = bus.mem_m_user[2*FRAC_WIDTH-1:FRAC_WIDTH];
    assign r_user = bus.mem_m_user[MEM_USER_WIDTH-1:2*FRAC_WIDTH];
    assign w_fx   = W_ONE - {1'b0, r_fx};
    assign w_fy   = W_ONE - {1'b0, fy_a_q};

    always_comb begin
        s_xi = bus.s_x[X_WIDTH-1:FRAC_WIDTH];
        s_yi = bus.s_y[Y_WIDTH-1:FRAC_WIDTH];
        s_fx = bus.s_x[FRAC_WIDTH-1:0];
        s_fy = bus.s_y[FRAC_WIDTH-1:0];
`ifdef JELLY_BILINEAR_CLAMP_EN
        // The +1 neighbour of the last column/row wraps to 0; give it no weight.
        if (&s_xi) s_fx = '0;
        if (&s_yi) s_fy = '0;
`endif
    end

    always_comb begin
        addrx_d    = addrx_q;
        addry_d    = addry_q;
        mem_user_d = mem_user_q;
        s0_valid_d = s0_valid_q;
        top_d      = top_q;
        bot_d      = bot_q;
        fy_a_d     = fy_a_q;
        user_a_d   = user_a_q;
        valid_a_d  = valid_a_q;
        v_d        = v_q;
        user_b_d   = user_b_q;
        valid_b_d  = valid_b_q;
        m_data_d   = m_data_q;
        m_user_d   = m_user_q;
        m_valid_d  = m_valid_q;
        if (cke) begin
            addrx_d    = s_xi;
            addry_d    = s_yi;
            mem_user_d = {bus.s_user, s_fy, s_fx};
            s0_valid_d = bus.s_valid;

            top_d      = TOP_WIDTH'(bus.mem_m_data0) * TOP_WIDTH'(w_fx)
                       + TOP_WIDTH'(bus.mem_m_data1) * TOP_WIDTH'(r_fx);
            bot_d      = TOP_WIDTH'(bus.mem_m_data2) * TOP_WIDTH'(w_fx)
                       + TOP_WIDTH'(bus.mem_m_data3) * TOP_WIDTH'(r_fx);
            fy_a_d     = r_fy;
            user_a_d   = r_user;
            valid_a_d  = bus.mem_m_valid;

            v_d        = V_WIDTH'(top_q) * V_WIDTH'(w_fy)
                       + V_WIDTH'(bot_q) * V_WIDTH'(fy_a_q);
            user_b_d   = user_a_q;
            valid_b_d  = valid_a_q;

            // Round half up; the weighted mean never exceeds the largest input pixel.
            m_data_d   = DATA_WIDTH'((v_q + ROUND_HALF) >> (2*FRAC_WIDTH));
            m_user_d   = user_b_q;
            m_valid_d  = valid_b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            valid_a_q  <= 1'b0;
            valid_b_q  <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
            valid_a_q  <= valid_a_d;
            valid_b_q  <= valid_b_d;
            m_valid_q  <= m_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        addrx_q    <= addrx_d;
        addry_q    <= addry_d;
        mem_user_q <= mem_user_d;
        top_q      <= top_d;
        bot_q      <= bot_d;
        fy_a_q     <= fy_a_d;
        user_a_q   <= user_a_d;
        v_q        <= v_d;
        user_b_q   <= user_b_d;
        m_data_q   <= m_data_d;
        m_user_q   <= m_user_d;
    end

endmodule

// File: tb/tb_jelly_bilinear_quad_sampler.sv
// Scoreboard bench for jelly_bilinear_quad_sampler with a 4-cycle quad-read RAM model.
// Build with +define+JELLY_BILINEAR_CLAMP_EN to exercise the edge-clamp variant.
module tb_jelly_bilinear_quad_sampler;
    localparam int UW  = 8;
    localparam int AXW = 8;
    localparam int AYW = 8;
    localparam int FW  = 4;
    localparam int DW  = 8;
    localparam int MUW = UW + 2*FW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    jelly_bilinear_quad_sampler_if #(
        .USER_WIDTH(UW), .ADDR_X_WIDTH(AXW), .ADDR_Y_WIDTH(AYW),
        .FRAC_WIDTH(FW), .DATA_WIDTH(DW)
    ) bus ();

    jelly_bilinear_quad_sampler #(
        .USER_WIDTH(UW), .ADDR_X_WIDTH(AXW), .ADDR_Y_WIDTH(AYW),
        .FRAC_WIDTH(FW), .DATA_WIDTH(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] img [0:255][0:255];

    // quad-read RAM: 4 cke-gated stages, x+1 / y+1 wrap modulo 256
    logic [3:0]     r_v;
    logic [MUW-1:0] r_u  [4];
    logic [7:0]     r_d0 [4];
    logic [7:0]     r_d1 [4];
    logic [7:0]     r_d2 [4];
    logic [7:0]     r_d3 [4];
    logic [7:0]     ax1, ay1;
    assign ax1 = bus.mem_s_addrx + 8'd1;
    assign ay1 = bus.mem_s_addry + 8'd1;

    always @(posedge clk) begin
        if (reset) begin
            r_v <= 4'b0;
        end else if (bus.mem_cke) begin
            r_v     <= {r_v[2:0], bus.mem_s_valid};
            r_u[0]  <= bus.mem_s_user;
            r_d0[0] <= img[bus.mem_s_addry][bus.mem_s_addrx];
            r_d1[0] <= img[bus.mem_s_addry][ax1];
            r_d2[0] <= img[ay1][bus.mem_s_addrx];
            r_d3[0] <= img[ay1][ax1];
            for (int k = 1; k < 4; k++) begin
                r_u[k]  <= r_u[k-1];
                r_d0[k] <= r_d0[k-1];
                r_d1[k] <= r_d1[k-1];
                r_d2[k] <= r_d2[k-1];
                r_d3[k] <= r_d3[k-1];
            end
        end
    end
    assign bus.mem_m_valid = r_v[3];
    assign bus.mem_m_user  = r_u[3];
    assign bus.mem_m_data0 = r_d0[3];
    assign bus.mem_m_data1 = r_d1[3];
    assign bus.mem_m_data2 = r_d2[3];
    assign bus.mem_m_data3 = r_d3[3];

    typedef struct {
        logic [7:0] u;
        logic [7:0] d;
        longint     c;
    } exp_t;
    exp_t sb[$];

    int     checks   = 0;
    int     failures = 0;
    longint cke_cnt  = 0;
    logic   rdy_s    = 1'b0;
    int     rmode    = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bilinear reference: weighted sum of the four neighbours, rounded half up.
    function automatic logic [7:0] ref_pix(input logic [11:0] x, input logic [11:0] y);
        int xi, yi, fx, fy, x1, y1, acc;
        xi = int'(x[11:4]);
        yi = int'(y[11:4]);
        fx = int'(x[3:0]);
        fy = int'(y[3:0]);
`ifdef JELLY_BILINEAR_CLAMP_EN
        if (xi == 255) fx = 0;
        if (yi == 255) fy = 0;
`endif
        x1 = (xi + 1) % 256;
        y1 = (yi + 1) % 256;
        acc = int'(img[yi][xi]) * (16 - fx) * (16 - fy)
            + int'(img[yi][x1]) * fx * (16 - fy)
            + int'(img[y1][xi]) * (16 - fx) * fy
            + int'(img[y1][x1]) * fx * fy;
        return 8'((acc + 128) >> 8);
    endfunction

    always @(posedge clk) begin
        if (rdy_s) cke_cnt <= cke_cnt + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        rdy_s = bus.s_ready;
        if (reset) begin
            sb.delete();
            chk("reset_m_valid", bus.m_valid, 0);
            chk("reset_mem_s_valid", bus.mem_s_valid, 0);
            chk("reset_s_ready", bus.s_ready, 1);
        end else begin
            chk("s_ready_rule", bus.s_ready, !(bus.m_valid && !bus.m_ready));
            chk("mem_cke", bus.mem_cke, bus.s_ready);
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_m_valid", bus.m_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("m_data", bus.m_data, e.d);
                    chk("m_user", bus.m_user, e.u);
                    chk("latency", cke_cnt, e.c + 8);
                end
            end
        end
    end

    initial begin
        int ph;
        ph = 0;
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus.m_ready = 1'b1;
                1: begin
                    bus.m_ready = (ph != 2);
                    ph = (ph + 1) % 3;
                end
                default: bus.m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [11:0] x, input logic [11:0] y,
                        input logic [7:0] u, input logic [7:0] e);
        int n;
        bus.s_x     = x;
        bus.s_y     = y;
        bus.s_user  = u;
        bus.s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", bus.s_ready, 1);
        if (bus.s_ready) sb.push_back(exp_t'{u: u, d: e, c: cke_cnt});
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", sb.size(), 0);
        idle(2);
    endtask

    function automatic logic [11:0] rnd_coord();
        logic [7:0] i;
        i = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        return {i, 4'($urandom_range(0, 15))};
    endfunction

    initial begin
        logic [11:0] x, y;
        bus.s_valid = 1'b0;
        bus.s_x     = '0;
        bus.s_y     = '0;
        bus.s_user  = '0;
        for (int j = 0; j < 256; j++)
            for (int i = 0; i < 256; i++)
                img[j][i] = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // constant image: every blend returns the constant
        for (int i = 0; i < 20; i++) begin
            send(rnd_coord(), rnd_coord(), 8'(i), 8'h5A);
            idle($urandom_range(0, 2));
        end
        drain();

        // directed blends around a 2x2 patch
        img[10][10] = 8'h00;
        img[10][11] = 8'h10;
        img[11][10] = 8'h20;
        img[11][11] = 8'h30;
        send({8'd10, 4'd8},  {8'd10, 4'd8}, 8'hA1, 8'h18);
        send({8'd10, 4'd0},  {8'd10, 4'd0}, 8'hA2, 8'h00);
        send({8'd10, 4'd15}, {8'd10, 4'd0}, 8'hA3, 8'h0F);
        img[0][255] = 8'h80;
        img[0][0]   = 8'h00;
`ifdef JELLY_BILINEAR_CLAMP_EN
        send({8'd255, 4'd8}, {8'd0, 4'd0}, 8'hA4, 8'h80);
`else
        send({8'd255, 4'd8}, {8'd0, 4'd0}, 8'hA4, 8'h40);
`endif
        drain();

        // random image; burst under a 3-cycle m_ready pattern
        for (int j = 0; j < 256; j++)
            for (int i = 0; i < 256; i++)
                img[j][i] = 8'($urandom_range(0, 255));
        rmode = 1;
        for (int i = 0; i < 16; i++) begin
            x = rnd_coord();
            y = rnd_coord();
            send(x, y, 8'(8'h40 + i), ref_pix(x, y));
        end
        drain();

        // random traffic with random back-pressure and gaps
        rmode = 2;
        for (int i = 0; i < 150; i++) begin
            x = rnd_coord();
            y = rnd_coord();
            send(x, y, 8'($urandom_range(0, 255)), ref_pix(x, y));
            idle($urandom_range(0, 1));
        end
        drain();

        // reset with samples in flight: they must never appear
        rmode = 0;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            x = rnd_coord();
            y = rnd_coord();
            send(x, y, 8'(8'hC0 + i), ref_pix(x, y));
        end
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(15);
        x = rnd_coord();
        y = rnd_coord();
        send(x, y, 8'hD5, ref_pix(x, y));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
